// File: rtl/cdb_pkg.sv
// Shared CDB result types: physical-register tag width helper and the result payload struct.
package cdb_pkg;

  localparam int DATA_W        = 32;
  localparam int NUM_PHYS_REGS = 64;
  localparam int ROB_IDX_W     = 7;

  function automatic int preg_bits(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  localparam int PREG_BITS = preg_bits(NUM_PHYS_REGS);

  typedef struct packed {
    logic [PREG_BITS-1:0] prd;
    logic [DATA_W-1:0]    data;
    logic [ROB_IDX_W-1:0] rob_idx;
  } cdb_result_t;

endpackage

// File: rtl/cdb_result_queue.sv
// Result FIFO in front of the CDB: buffers a unit's completed results and holds the
// oldest one on the valid/ack handshake until the arbiter grants it.
module cdb_result_queue
  import cdb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PREG_BITS-1:0] in_prd,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [ROB_IDX_W-1:0] in_rob_idx,
  output logic                 out_valid,
  output logic [PREG_BITS-1:0] out_prd,
  output logic [DATA_W-1:0]    out_data,
  output logic [ROB_IDX_W-1:0] out_rob_idx,
  input  logic                 out_ack,
  output logic [CNT_W-1:0]     count,
  output logic [15:0]          stall_cycles
);

  cdb_result_t            mem [DEPTH];
  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;
  logic                   push;
  logic                   pop;
  cdb_result_t            head_entry;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Handshake qualifiers, all from registered occupancy
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_ack & out_valid;

  // Control state: pointers, occupancy, stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      stall_cycles <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (out_valid && !out_ack) stall_cycles <= sat_inc16(stall_cycles);
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem[tail] <= '{prd: in_prd, data: in_data, rob_idx: in_rob_idx};
    end
  end

  assign head_entry  = mem[head];
  assign out_prd     = head_entry.prd;
  assign out_data    = head_entry.data;
  assign out_rob_idx = head_entry.rob_idx;

endmodule

// File: tb/tb_cdb_result_queue.sv
// Scoreboard bench for cdb_result_queue: stimulus pushes expected payloads, a negedge
// monitor pops and compares on every acked handshake.
module tb_cdb_result_queue;
  import cdb_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 flush = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [PREG_BITS-1:0] in_prd = '0;
  logic [DATA_W-1:0]    in_data = '0;
  logic [ROB_IDX_W-1:0] in_rob_idx = '0;
  logic                 out_valid;
  logic [PREG_BITS-1:0] out_prd;
  logic [DATA_W-1:0]    out_data;
  logic [ROB_IDX_W-1:0] out_rob_idx;
  logic                 out_ack = 1'b0;
  logic [CNT_W-1:0]     count;
  logic [15:0]          stall_cycles;

  cdb_result_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_prd(in_prd), .in_data(in_data), .in_rob_idx(in_rob_idx),
    .out_valid(out_valid), .out_prd(out_prd), .out_data(out_data),
    .out_rob_idx(out_rob_idx), .out_ack(out_ack),
    .count(count), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  cdb_result_t exp_q[$];
  int          mcount = 0;
  logic [15:0] mstall = '0;

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every accepted handshake must present the oldest expected payload
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ack) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL pop_empty: got data 0x%0h expected no entry", out_data);
      end else begin
        cdb_result_t e;
        e = exp_q.pop_front();
        if (out_prd == e.prd && out_data == e.data && out_rob_idx == e.rob_idx) pass_cnt++;
        else $display("FAIL pop_payload: got prd=%0d data=0x%0h rob=%0d expected prd=%0d data=0x%0h rob=%0d",
                      out_prd, out_data, out_rob_idx, e.prd, e.data, e.rob_idx);
      end
    end
    if (!rst && out_ack && !out_valid) begin
      total_cnt++;
      $display("FAIL illegal_ack: got out_ack=1 with out_valid=0 expected no ack");
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    mcount = 0;
    mstall = '0;
    exp_q.delete();
  endtask

  // One clock of stimulus; the bench model decides acceptance independently of the DUT
  task automatic step(input logic iv, input logic [PREG_BITS-1:0] prd, input logic [DATA_W-1:0] d,
                      input logic [ROB_IDX_W-1:0] rob, input logic ack, input logic fl);
    bit acc, pp;
    in_valid = iv; in_prd = prd; in_data = d; in_rob_idx = rob;
    out_ack = ack; flush = fl;
    if (fl) begin
      mcount = 0;
      exp_q.delete();
    end else begin
      acc = iv && (mcount != DEPTH);
      pp  = ack && (mcount != 0);
      if (mcount != 0 && !ack && mstall != 16'hFFFF) mstall = mstall + 16'd1;
      if (acc) exp_q.push_back('{prd: prd, data: d, rob_idx: rob});
      mcount = mcount + int'(acc) - int'(pp);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ack = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic push1(input logic [DATA_W-1:0] d);
    step(1'b1, PREG_BITS'(d[5:0]), d, ROB_IDX_W'(d[6:0]), 1'b0, 1'b0);
  endtask

  task automatic ack1();
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [15:0] held;

    // 1: reset and idle
    do_reset();
    idle(2);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_count", count, 0);
    check("rst_stall", stall_cycles, 0);

    // 2: single entry, held three cycles, then acked
    step(1'b1, 6'd5, 32'hDEAD_BEEF, 7'd3, 1'b0, 1'b0);
    check("t2_out_valid", out_valid, 1);
    check("t2_out_data", out_data, 32'hDEAD_BEEF);
    check("t2_out_prd", out_prd, 5);
    check("t2_out_rob", out_rob_idx, 3);
    idle(3);
    check("t2_stall", stall_cycles, 3);
    ack1();
    check("t2_valid_after_ack", out_valid, 0);
    check("t2_count_after_ack", count, 0);
    check("t2_stall_held", stall_cycles, 3);

    // 3: fill, refused fifth push, drain in order across the wrap
    for (int i = 1; i <= 4; i++) push1(32'(i));
    check("t3_count_full", count, 4);
    check("t3_in_ready_full", in_ready, 0);
    push1(32'd5);
    check("t3_count_refused", count, 4);
    for (int i = 0; i < 4; i++) ack1();
    check("t3_count_drained", count, 0);
    check("t3_valid_drained", out_valid, 0);
    check("t3_stall_model", stall_cycles, mstall);

    // 4: steady push+ack at count=2
    push1(32'h100);
    push1(32'h101);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 6'(i), 32'h102 + 32'(i), 7'(i), 1'b1, 1'b0);
      check("t4_count_steady", count, 2);
    end
    ack1();
    ack1();
    check("t4_count_drained", count, 0);
    check("t4_queue_empty", exp_q.size(), 0);

    // 5: flush with a concurrent push and ack
    push1(32'h200);
    push1(32'h201);
    push1(32'h202);
    check("t5_count_pre", count, 3);
    held = stall_cycles;
    step(1'b1, 6'd9, 32'h2FF, 7'd9, 1'b1, 1'b1);
    check("t5_count_flush", count, 0);
    check("t5_valid_flush", out_valid, 0);
    check("t5_stall_held", stall_cycles, held);
    idle(1);
    check("t5_no_new_entry", out_valid, 0);
    check("t5_in_ready", in_ready, 1);

    // 6: saturation of the stall counter
    push1(32'h300);
    idle(70000);
    check("t6_stall_sat", stall_cycles, 16'hFFFF);
    idle(2);
    check("t6_stall_nowrap", stall_cycles, 16'hFFFF);
    ack1();
    check("t6_count_drained", count, 0);

    // Reset mid-operation
    push1(32'h400);
    push1(32'h401);
    do_reset();
    check("rst2_count", count, 0);
    check("rst2_out_valid", out_valid, 0);
    check("rst2_stall", stall_cycles, 0);
    push1(32'h500);
    ack1();
    check("rst2_reuse_count", count, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
